sdr_bank_tracker: RTL and testbench
===================================

# sdr_bank_tracker

Passive per-bank SDRAM protocol tracker, directly downstream of the SDRAM pin bus. It samples the command pins (cke/cs/ras/cas/we), bank and address each clock, keeps each of the 4 banks' state and open row, and drives the `bank_st` vector that the bus-level bank sequences evaluate. It checks activate/precharge/transfer timing and ordering and reports every violation as a registered one-cycle pulse with a code and a bank number.

## Interface
- T_RCD, 3: ACTIVE to READ/WRITE, in cycles (≥1).
- T_RAS, 6: ACTIVE to PRECHARGE, in cycles (≥1).
- T_RP, 3: PRECHARGE to ACTIVE, in cycles (≥1).
- BURST_LEN, 4: beats per READ/WRITE burst (1..8).
- sdram_clk  in  1  SDRAM clock; all sampling on the rising edge.
- sdram_reset  in  1  reset, asynchronous, active-high.
- sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n  in  1 each  command pins.
- sdr_ba  in  2  bank address.
- sdr_addr  in  13  row/column address; bit 10 selects precharge-all.
- bank_st  out  [3:0][2:0]  per-bank state: IDLE=000, PRE=001, ACT=010, XFR=011.
- open_row  out  [3:0][12:0]  row latched at the last ACTIVE per bank.
- viol  out  1  violation pulse.
- viol_code  out  3  1 ACT_OPEN, 2 RW_CLOSED, 3 TRCD, 4 TRAS, 5 TRP, 6 NOT_IDLE.
- viol_bank  out  2  bank that violated.
- viol_cnt  out  16  violation count; saturates at 0xFFFF.

## Operation
- Command decode: cmd = {cs_n, ras_n, cas_n, we_n}.
  - cke=0 or cs_n=1 means NOP.
  - 0011 ACTIVE, 0101 READ, 0100 WRITE, 0110 BURST_TERMINATE, 0010 PRECHARGE, 0001 AUTO_REFRESH, 0000 LOAD_MODE, 0111 NOP.
- Per-bank counters: rcd_cnt, ras_cnt, rp_cnt (down-counting, stop at 0) and bcnt (burst).
- Per-bank FSM, for bank b = sdr_ba:
  - IDLE + ACTIVE(b): go to ACT. open_row[b] = addr. rcd_cnt = T_RCD-1, ras_cnt = T_RAS-1.
  - IDLE + PRECHARGE: legal no-op.
  - IDLE + READ/WRITE(b): RW_CLOSED; state unchanged.
  - ACT + READ/WRITE(b): go to XFR, bcnt = BURST_LEN-1. TRCD violation if rcd_cnt≠0, but the transition still occurs.
  - ACT + PRECHARGE(b), or precharge-all: go to PRE, rp_cnt = T_RP-1. TRAS violation if ras_cnt≠0, but the transition still occurs.
  - ACT + ACTIVE(b): ACT_OPEN; state and open_row unchanged.
  - XFR: bcnt decrements every cycle.
    - bcnt==0 with no new READ/WRITE(b): go to ACT.
    - READ/WRITE(b): restart the burst (bcnt = BURST_LEN-1).
    - BURST_TERMINATE: every XFR bank goes to ACT.
    - PRECHARGE(b) or precharge-all: go to PRE, with the same TRAS check as from ACT.
  - PRE: rp_cnt decrements.
    - rp_cnt==0 with no command to b: go to IDLE.
    - ACTIVE(b) with rp_cnt==0: legal; go straight to ACT.
    - ACTIVE(b) with rp_cnt≠0: TRP; state unchanged.
    - READ/WRITE(b): RW_CLOSED.
- addr[10] on READ/WRITE is ignored; auto-precharge is not tracked.
- AUTO_REFRESH or LOAD_MODE while any bank is not IDLE: NOT_IDLE. viol_bank = lowest non-IDLE bank. No state change.
- At most one command per cycle. For a multi-bank violation (precharge-all), report the lowest bank.
- viol_cnt increments once per viol pulse.

## Timing
- All outputs are registered and update on the edge after the command is sampled.
  - Example: ACTIVE sampled at edge N makes bank_st = ACT visible from N+1.
- READ/WRITE at edge N+k after ACTIVE at edge N is legal iff k ≥ T_RCD. PRECHARGE is legal iff k ≥ T_RAS.
- After PRECHARGE at edge N: ACTIVE is legal at edge N+T_RP or later. Without a new command the bank reads IDLE from N+T_RP+1.
- XFR is visible for exactly BURST_LEN cycles after a single READ/WRITE.
- viol is high for exactly one cycle per violating command. Violations on back-to-back cycles give back-to-back pulses.
- Reset:
  - bank_st = IDLE, open_row = 0, all counters 0, viol/viol_code/viol_bank = 0, viol_cnt = 0.
  - Asserting reset mid-burst clears everything immediately, without waiting for a clock edge.
  - The first command is sampled at the first rising edge after reset deasserts.

## Test plan
All scenarios use the default parameters.
- Reset with random pin values → every output is 0 during reset and on the first cycle after release.
- ACTIVE ba=2, row 0x155 at edge 0; READ ba=2 at edge 3:
  - bank_st[2] = ACT from cycle 1 and XFR during cycles 4–7, then ACT from cycle 8.
  - open_row[2] = 0x155; viol never asserts.
- ACTIVE ba=0 at edge 0; WRITE ba=0 at edge 2 → viol=1, code 3, bank 0 in cycle 3; bank_st[0] = XFR; viol_cnt = 1.
- Banks 1 and 3 open since edge 0; precharge-all (addr[10]=1) at edge 8; ACTIVE ba=1 at edge 10:
  - code 5, bank 1; both banks stay PRE.
  - Both banks are IDLE from cycle 12.
- Bank 3 in ACT; AUTO_REFRESH → code 6, bank 3. Then READ to idle bank 0 → code 2, bank 0 on the next cycle; viol_cnt = 2.
- ACTIVE then READ on bank 1; assert reset asynchronously mid-burst → bank_st, viol_cnt and open_row clear before the next clock edge.

Source files
------------

// File: rtl/sdr_bank_tracker_if.sv
// rtl/sdr_bank_tracker_if.sv - SDRAM command pin bus seen by the bank tracker
interface sdr_bank_tracker_if;
    logic        sdr_cke;
    logic        sdr_cs_n;
    logic        sdr_ras_n;
    logic        sdr_cas_n;
    logic        sdr_we_n;
    logic [1:0]  sdr_ba;
    logic [12:0] sdr_addr;

    // Controller side drives the pins.
    modport master (
        output sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_addr
    );

    // Tracker side only observes them.
    modport slave (
        input  sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_addr
    );
endinterface

// File: rtl/sdr_bank_tracker.sv
// rtl/sdr_bank_tracker.sv - passive per-bank SDRAM state and timing tracker
module sdr_bank_tracker #(
    parameter int T_RCD     = 3,
    parameter int T_RAS     = 6,
    parameter int T_RP      = 3,
    parameter int BURST_LEN = 4
) (
    input  logic              sdram_clk,
    input  logic              sdram_reset,
    sdr_bank_tracker_if.slave bus,
    output logic [3:0][2:0]   bank_st,
    output logic [3:0][12:0]  open_row,
    output logic              viol,
    output logic [2:0]        viol_code,
    output logic [1:0]        viol_bank,
    output logic [15:0]       viol_cnt
);
    localparam logic [2:0] ST_IDLE = 3'b000;
    localparam logic [2:0] ST_PRE  = 3'b001;
    localparam logic [2:0] ST_ACT  = 3'b010;
    localparam logic [2:0] ST_XFR  = 3'b011;

    localparam logic [2:0] V_NONE      = 3'd0;
    localparam logic [2:0] V_ACT_OPEN  = 3'd1;
    localparam logic [2:0] V_RW_CLOSED = 3'd2;
    localparam logic [2:0] V_TRCD      = 3'd3;
    localparam logic [2:0] V_TRAS      = 3'd4;
    localparam logic [2:0] V_TRP       = 3'd5;
    localparam logic [2:0] V_NOT_IDLE  = 3'd6;

    localparam int            CW         = 8;
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] RCD_LOAD   = CW'(T_RCD - 1);
    localparam logic [CW-1:0] RAS_LOAD   = CW'(T_RAS - 1);
    localparam logic [CW-1:0] RP_LOAD    = CW'(T_RP - 1);
    localparam logic [2:0]    BURST_LOAD = 3'(BURST_LEN - 1);

    logic [3:0][CW-1:0] rcd_cnt, ras_cnt, rp_cnt;
    logic [3:0][2:0]    bcnt;

    logic [3:0][2:0]    st_nx;
    logic [3:0][12:0]   row_nx;
    logic [3:0][CW-1:0] rcd_nx, ras_nx, rp_nx;
    logic [3:0][2:0]    bcnt_nx;
    logic [3:0][2:0]    bank_code;

    logic       cmd_act, cmd_rw, cmd_bt, cmd_pre, cmd_ref_lmr;
    logic [3:0] hit, pre_hit;
    logic [2:0] code_nx;
    logic [1:0] bank_nx;

    // Decode the pin bus into one command strobe plus the targeted bank(s).
    always_comb begin
        cmd_act     = 1'b0;
        cmd_rw      = 1'b0;
        cmd_bt      = 1'b0;
        cmd_pre     = 1'b0;
        cmd_ref_lmr = 1'b0;
        if (bus.sdr_cke && !bus.sdr_cs_n) begin
            case ({bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n})
                3'b011:         cmd_act     = 1'b1;
                3'b101, 3'b100: cmd_rw      = 1'b1;
                3'b110:         cmd_bt      = 1'b1;
                3'b010:         cmd_pre     = 1'b1;
                3'b001, 3'b000: cmd_ref_lmr = 1'b1;
                default:        ;
            endcase
        end
        hit     = 4'b0001 << bus.sdr_ba;
        pre_hit = (cmd_pre && bus.sdr_addr[10]) ? 4'b1111 : (cmd_pre ? hit : 4'b0000);
    end

    // Per-bank next state, counters and candidate violation code.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            st_nx[b]     = bank_st[b];
            row_nx[b]    = open_row[b];
            rcd_nx[b]    = (rcd_cnt[b] != '0) ? rcd_cnt[b] - CNT_ONE : '0;
            ras_nx[b]    = (ras_cnt[b] != '0) ? ras_cnt[b] - CNT_ONE : '0;
            rp_nx[b]     = (rp_cnt[b]  != '0) ? rp_cnt[b]  - CNT_ONE : '0;
            bcnt_nx[b]   = (bcnt[b]    != '0) ? bcnt[b]    - 3'd1    : '0;
            bank_code[b] = V_NONE;
            case (bank_st[b])
                ST_IDLE: begin
                    if (cmd_act && hit[b]) begin
                        st_nx[b]  = ST_ACT;
                        row_nx[b] = bus.sdr_addr;
                        rcd_nx[b] = RCD_LOAD;
                        ras_nx[b] = RAS_LOAD;
                    end else if (cmd_rw && hit[b]) begin
                        bank_code[b] = V_RW_CLOSED;
                    end
                end
                ST_ACT: begin
                    if (cmd_rw && hit[b]) begin
                        st_nx[b]   = ST_XFR;
                        bcnt_nx[b] = BURST_LOAD;
                        if (rcd_cnt[b] != '0) bank_code[b] = V_TRCD;
                    end else if (pre_hit[b]) begin
                        st_nx[b] = ST_PRE;
                        rp_nx[b] = RP_LOAD;
                        if (ras_cnt[b] != '0) bank_code[b] = V_TRAS;
                    end else if (cmd_act && hit[b]) begin
                        bank_code[b] = V_ACT_OPEN;
                    end
                end
                ST_XFR: begin
                    if (cmd_rw && hit[b]) begin
                        bcnt_nx[b] = BURST_LOAD;
                    end else if (pre_hit[b]) begin
                        st_nx[b] = ST_PRE;
                        rp_nx[b] = RP_LOAD;
                        if (ras_cnt[b] != '0) bank_code[b] = V_TRAS;
                    end else if (cmd_bt) begin
                        st_nx[b] = ST_ACT;
                    end else begin
                        // A stray ACTIVE is flagged but does not stall the burst.
                        if (cmd_act && hit[b]) bank_code[b] = V_ACT_OPEN;
                        if (bcnt[b] == '0) st_nx[b] = ST_ACT;
                    end
                end
                ST_PRE: begin
                    if (cmd_act && hit[b]) begin
                        if (rp_cnt[b] == '0) begin
                            st_nx[b]  = ST_ACT;
                            row_nx[b] = bus.sdr_addr;
                            rcd_nx[b] = RCD_LOAD;
                            ras_nx[b] = RAS_LOAD;
                        end else begin
                            bank_code[b] = V_TRP;
                        end
                    end else begin
                        if (cmd_rw && hit[b]) bank_code[b] = V_RW_CLOSED;
                        if (rp_cnt[b] == '0) st_nx[b] = ST_IDLE;
                    end
                end
                default: st_nx[b] = ST_IDLE;
            endcase
        end
    end

    // Pick the single reported violation: lowest offending bank wins.
    always_comb begin
        code_nx = V_NONE;
        bank_nx = 2'd0;
        if (cmd_ref_lmr) begin
            for (int b = 3; b >= 0; b--) begin
                if (bank_st[b] != ST_IDLE) begin
                    code_nx = V_NOT_IDLE;
                    bank_nx = 2'(b);
                end
            end
        end else begin
            for (int b = 3; b >= 0; b--) begin
                if (bank_code[b] != V_NONE) begin
                    code_nx = bank_code[b];
                    bank_nx = 2'(b);
                end
            end
        end
    end

    // Register bank state, counters and the violation outputs.
    always_ff @(posedge sdram_clk or posedge sdram_reset) begin
        if (sdram_reset) begin
            bank_st   <= '0;
            open_row  <= '0;
            rcd_cnt   <= '0;
            ras_cnt   <= '0;
            rp_cnt    <= '0;
            bcnt      <= '0;
            viol      <= 1'b0;
            viol_code <= V_NONE;
            viol_bank <= 2'd0;
            viol_cnt  <= 16'd0;
        end else begin
            bank_st   <= st_nx;
            open_row  <= row_nx;
            rcd_cnt   <= rcd_nx;
            ras_cnt   <= ras_nx;
            rp_cnt    <= rp_nx;
            bcnt      <= bcnt_nx;
            viol      <= (code_nx != V_NONE);
            viol_code <= code_nx;
            viol_bank <= bank_nx;
            if (code_nx != V_NONE && viol_cnt != 16'hFFFF) begin
                viol_cnt <= viol_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_sdr_bank_tracker.sv
// tb/tb_sdr_bank_tracker.sv - self-checking bench for sdr_bank_tracker
module tb_sdr_bank_tracker;
    localparam int T_RCD = 3;
    localparam int T_RAS = 6;
    localparam int T_RP  = 3;
    localparam int BL    = 4;

    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_BT  = 4'b0110;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_LMR = 4'b0000;
    localparam logic [3:0] C_NOP = 4'b0111;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sdr_bank_tracker_if bus_if ();

    logic [3:0][2:0]  bank_st;
    logic [3:0][12:0] open_row;
    logic             viol;
    logic [2:0]       viol_code;
    logic [1:0]       viol_bank;
    logic [15:0]      viol_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    sdr_bank_tracker #(.T_RCD(T_RCD), .T_RAS(T_RAS), .T_RP(T_RP), .BURST_LEN(BL)) dut (
        .sdram_clk   (clk),
        .sdram_reset (rst),
        .bus         (bus_if),
        .bank_st     (bank_st),
        .open_row    (open_row),
        .viol        (viol),
        .viol_code   (viol_code),
        .viol_bank   (viol_bank),
        .viol_cnt    (viol_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Timestamp-based model: each bank remembers when it was activated,
    // precharged and when its burst ends, instead of running counters.
    int         m_st [4];
    logic [12:0] m_row [4];
    longint     t_act [4];
    longint     t_pre [4];
    longint     t_bend [4];
    longint     m_edge;
    int         m_viol, m_code, m_bank, m_cnt;

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            m_st[b] = 0; m_row[b] = '0;
            t_act[b] = -1000; t_pre[b] = -1000; t_bend[b] = -1000;
        end
        m_edge = 0; m_viol = 0; m_code = 0; m_bank = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        logic [3:0] c;
        int code [4];
        int nb_code, nb_bank;
        bit hit, act_b, rw_b, pre_b;
        longint since_act, since_pre;
        c = {bus_if.sdr_cs_n, bus_if.sdr_ras_n, bus_if.sdr_cas_n, bus_if.sdr_we_n};
        if (!bus_if.sdr_cke || bus_if.sdr_cs_n) c = C_NOP;
        nb_code = 0; nb_bank = 0;
        if (c == C_REF || c == C_LMR) begin
            for (int b = 3; b >= 0; b--) if (m_st[b] != 0) begin nb_code = 6; nb_bank = b; end
        end
        for (int b = 0; b < 4; b++) begin
            code[b]   = 0;
            hit       = (int'(bus_if.sdr_ba) == b);
            act_b     = (c == C_ACT) && hit;
            rw_b      = (c == C_RD || c == C_WR) && hit;
            pre_b     = (c == C_PRE) && (hit || bus_if.sdr_addr[10]);
            since_act = m_edge - t_act[b];
            since_pre = m_edge - t_pre[b];
            case (m_st[b])
                0: if (act_b) begin m_st[b] = 2; m_row[b] = bus_if.sdr_addr; t_act[b] = m_edge; end
                   else if (rw_b) code[b] = 2;
                2: if (rw_b) begin
                       if (since_act < T_RCD) code[b] = 3;
                       m_st[b] = 3; t_bend[b] = m_edge + BL;
                   end else if (pre_b) begin
                       if (since_act < T_RAS) code[b] = 4;
                       m_st[b] = 1; t_pre[b] = m_edge;
                   end else if (act_b) code[b] = 1;
                3: if (rw_b) t_bend[b] = m_edge + BL;
                   else if (pre_b) begin
                       if (since_act < T_RAS) code[b] = 4;
                       m_st[b] = 1; t_pre[b] = m_edge;
                   end else if (c == C_BT) m_st[b] = 2;
                   else begin
                       if (act_b) code[b] = 1;
                       if (m_edge >= t_bend[b]) m_st[b] = 2;
                   end
                default: if (act_b) begin
                       if (since_pre >= T_RP) begin
                           m_st[b] = 2; m_row[b] = bus_if.sdr_addr; t_act[b] = m_edge;
                       end else code[b] = 5;
                   end else begin
                       if (rw_b) code[b] = 2;
                       if (since_pre >= T_RP) m_st[b] = 0;
                   end
            endcase
        end
        if (nb_code == 0) begin
            for (int b = 3; b >= 0; b--) if (code[b] != 0) begin nb_code = code[b]; nb_bank = b; end
        end
        m_viol = (nb_code != 0) ? 1 : 0;
        m_code = nb_code;
        m_bank = nb_bank;
        if (m_viol == 1 && m_cnt < 65535) m_cnt++;
        m_edge++;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // Every cycle, away from the active edge, compare DUT against the model.
    logic [3:0][2:0]  exp_st;
    logic [3:0][12:0] exp_row;
    always @(negedge clk) begin
        for (int b = 0; b < 4; b++) begin
            exp_st[b]  = 3'(m_st[b]);
            exp_row[b] = m_row[b];
        end
        chk("model bank_st",   bank_st,   exp_st);
        chk("model open_row",  open_row,  exp_row);
        chk("model viol",      viol,      m_viol);
        chk("model viol_code", viol_code, m_code);
        chk("model viol_bank", viol_bank, m_bank);
        chk("model viol_cnt",  viol_cnt,  m_cnt);
    end

    task automatic set_pins(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] addr);
        bus_if.sdr_cke   = 1'b1;
        bus_if.sdr_cs_n  = c[3];
        bus_if.sdr_ras_n = c[2];
        bus_if.sdr_cas_n = c[1];
        bus_if.sdr_we_n  = c[0];
        bus_if.sdr_ba    = ba;
        bus_if.sdr_addr  = addr;
    endtask

    // Present one command for the next rising edge; return just after it.
    task automatic step(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] addr);
        set_pins(c, ba, addr);
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(C_NOP, 2'd0, 13'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus_if.sdr_cke   = 1'($urandom);
            bus_if.sdr_cs_n  = 1'($urandom);
            bus_if.sdr_ras_n = 1'($urandom);
            bus_if.sdr_cas_n = 1'($urandom);
            bus_if.sdr_we_n  = 1'($urandom);
            bus_if.sdr_ba    = 2'($urandom);
            bus_if.sdr_addr  = 13'($urandom);
            @(posedge clk);
            #1;
        end
        set_pins(C_NOP, 2'd0, 13'd0);
        rst = 1'b0;
    endtask

    initial begin
        set_pins(C_NOP, 2'd0, 13'd0);

        // Reset with random pins: outputs stay zero during and right after reset.
        do_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_if.sdr_cke   = 1'b1;
            bus_if.sdr_cs_n  = 1'b0;
            bus_if.sdr_ras_n = 1'($urandom);
            bus_if.sdr_cas_n = 1'($urandom);
            bus_if.sdr_we_n  = 1'($urandom);
            bus_if.sdr_ba    = 2'($urandom);
            bus_if.sdr_addr  = 13'($urandom);
            @(posedge clk);
            #1;
            chk("reset bank_st", bank_st, 0);
            chk("reset viol_cnt", viol_cnt, 0);
            chk("reset outputs", {open_row, viol, viol_code, viol_bank}, 0);
        end
        set_pins(C_NOP, 2'd0, 13'd0);
        rst = 1'b0;
        step(C_NOP, 2'd0, 13'd0);
        chk("post-reset all", {bank_st, open_row, viol, viol_code, viol_bank, viol_cnt}, 0);

        // Legal ACTIVE/READ on bank 2.
        step(C_ACT, 2'd2, 13'h155);            // edge 0
        chk("s2 act st", bank_st[2], 3'b010);
        chk("s2 row", open_row[2], 13'h155);
        nops(2);                                // edges 1,2
        step(C_RD, 2'd2, 13'h000);             // edge 3
        chk("s2 xfr c4", bank_st[2], 3'b011);
        chk("s2 no viol c4", viol, 0);
        nops(3);                                // edges 4..6
        chk("s2 xfr c7", bank_st[2], 3'b011);
        nops(1);                                // edge 7
        chk("s2 act c8", bank_st[2], 3'b010);
        chk("s2 viol_cnt", viol_cnt, 0);

        // tRCD violation on WRITE.
        do_reset();
        step(C_ACT, 2'd0, 13'h011);            // edge 0
        nops(1);                                // edge 1
        step(C_WR, 2'd0, 13'h000);             // edge 2
        chk("s3 viol", viol, 1);
        chk("s3 code", viol_code, 3);
        chk("s3 bank", viol_bank, 0);
        chk("s3 st", bank_st[0], 3'b011);
        chk("s3 cnt", viol_cnt, 1);

        // Precharge-all followed by an early ACTIVE (tRP).
        do_reset();
        step(C_ACT, 2'd1, 13'h0aa);            // edge 0
        step(C_ACT, 2'd3, 13'h0bb);            // edge 1
        nops(6);                                // edges 2..7
        step(C_PRE, 2'd0, 13'h400);            // edge 8
        chk("s4 pre-all no viol", viol, 0);
        nops(1);                                // edge 9
        step(C_ACT, 2'd1, 13'h0cc);            // edge 10
        chk("s4 code", viol_code, 5);
        chk("s4 bank", viol_bank, 1);
        chk("s4 st1 pre", bank_st[1], 3'b001);
        chk("s4 st3 pre", bank_st[3], 3'b001);
        nops(1);                                // edge 11
        chk("s4 idle c12", {bank_st[3], bank_st[1]}, 0);

        // Refresh with an open bank, then READ to a closed bank.
        do_reset();
        step(C_ACT, 2'd3, 13'h033);
        step(C_REF, 2'd0, 13'h000);
        chk("s5 ref code", viol_code, 6);
        chk("s5 ref bank", viol_bank, 3);
        step(C_RD, 2'd0, 13'h000);
        chk("s5 rd code", viol_code, 2);
        chk("s5 rd bank", viol_bank, 0);
        chk("s5 cnt", viol_cnt, 2);

        // ACT_OPEN then tRAS back-to-back, idle timing, burst terminate.
        do_reset();
        step(C_ACT, 2'd0, 13'h001);            // edge 0
        step(C_ACT, 2'd0, 13'h002);            // edge 1
        chk("s7 act_open", viol_code, 1);
        chk("s7 row kept", open_row[0], 13'h001);
        step(C_PRE, 2'd0, 13'h000);            // edge 2
        chk("s7 tras", {viol, viol_code}, {1'b1, 3'd4});
        nops(2);                                // edges 3,4
        chk("s7 still pre", bank_st[0], 3'b001);
        nops(1);                                // edge 5
        chk("s7 idle", bank_st[0], 3'b000);
        step(C_ACT, 2'd2, 13'h1ff);
        nops(2);
        step(C_RD, 2'd2, 13'h000);
        nops(1);
        step(C_BT, 2'd0, 13'h000);
        chk("s7 bt act", bank_st[2], 3'b010);
        step(C_LMR, 2'd0, 13'h000);
        chk("s7 lmr code", viol_code, 6);

        // Mixed command stream, checked by the model only.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            logic [3:0] c;
            case ($urandom_range(0, 9))
                0, 1, 2: c = C_ACT;
                3, 4:    c = C_RD;
                5:       c = C_WR;
                6:       c = C_PRE;
                7:       c = C_BT;
                8:       c = ($urandom_range(0, 3) == 0) ? C_REF : C_LMR;
                default: c = C_NOP;
            endcase
            step(c, 2'($urandom), 13'($urandom));
        end

        // Asynchronous reset in the middle of a burst.
        do_reset();
        step(C_ACT, 2'd1, 13'h077);
        nops(1);
        step(C_RD, 2'd1, 13'h000);
        nops(1);
        chk("s6 pre-reset xfr", bank_st[1], 3'b011);
        chk("s6 pre-reset cnt", viol_cnt, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("s6 async st", bank_st, 0);
        chk("s6 async cnt", viol_cnt, 0);
        chk("s6 async row", open_row, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        nops(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
